// File: rtl/dmem_responder.sv
// Data-memory target for the PMIPS core: word RAM plus a small memory-mapped I/O page
// (LEDs, debounced switches/button, cycle counter, interval timer, sticky status).
module dmem_responder #(
    parameter int ADDR_W    = 10,
    parameter int DB_CYCLES = 50000,
    parameter int DB_W      = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] dmemaddr,
    input  logic [15:0] dmemwdata,
    input  logic        dmemwrite,
    input  logic        dmemread,
    output logic [15:0] dmemrdata,
    input  logic [3:0]  sw,
    input  logic        btn,
    output logic [7:0]  led,
    output logic        timer_flag
);

    localparam logic [6:0] OFF_LED    = 7'h00;
    localparam logic [6:0] OFF_INPUT  = 7'h01;
    localparam logic [6:0] OFF_CYCLE  = 7'h02;
    localparam logic [6:0] OFF_TCMP   = 7'h03;
    localparam logic [6:0] OFF_STATUS = 7'h04;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [15:0]       ram [0:(2**ADDR_W)-1];
    logic [ADDR_W-1:0] ram_idx;
    logic              is_io;
    logic [6:0]        io_off;
    logic              unused_bit0;

    logic              wr_ok;
    logic              ram_we;
    logic              led_we;
    logic              tcmp_we;
    logic              stat_clr;

    logic [4:0]        sync1;
    logic [4:0]        sync2;
    logic [4:0]        db_val;
    logic [DB_W-1:0]   db_cnt [0:4];
    logic              btn_rise;

    logic [15:0]       cycle;
    logic [15:0]       tcmp;
    logic [15:0]       tcnt;
    logic              timer_ev;
    logic [1:0]        status;

    assign is_io       = &dmemaddr[15:8];
    assign io_off      = dmemaddr[7:1];
    assign ram_idx     = dmemaddr[ADDR_W:1];
    assign unused_bit0 = dmemaddr[0];

    assign wr_ok    = reset & dmemwrite;
    assign ram_we   = wr_ok & ~is_io;
    assign led_we   = wr_ok & is_io & (io_off == OFF_LED);
    assign tcmp_we  = wr_ok & is_io & (io_off == OFF_TCMP);
    assign stat_clr = reset & dmemread & is_io & (io_off == OFF_STATUS);

    // RAM is deliberately left out of reset; only the write is gated by it.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            ram[ram_idx] <= dmemwdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            led <= 8'h00;
        end else if (led_we) begin
            led <= dmemwdata[7:0];
        end
    end

    // Bit 4 carries the button, bits 3:0 the switches.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1  <= '0;
            sync2  <= '0;
            db_val <= '0;
            for (int i = 0; i < 5; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= {btn, sw};
            sync2 <= sync1;
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] != db_val[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db_val[i] <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Fires on the same edge that the debounced button rises.
    assign btn_rise = sync2[4] & ~db_val[4] & (db_cnt[4] == DB_LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            cycle <= 16'h0000;
        end else begin
            cycle <= cycle + 16'h0001;
        end
    end

    assign timer_ev = ~tcmp_we & (tcmp != 16'h0000) & (tcnt == tcmp - 16'h0001);

    always_ff @(posedge clock) begin
        if (!reset) begin
            tcmp <= 16'h0000;
            tcnt <= 16'h0000;
        end else if (tcmp_we) begin
            tcmp <= dmemwdata;
            tcnt <= 16'h0000;
        end else if (tcmp == 16'h0000 || timer_ev) begin
            tcnt <= 16'h0000;
        end else begin
            tcnt <= tcnt + 16'h0001;
        end
    end

    // A set arriving in the same cycle as a read-clear keeps the bit high.
    always_ff @(posedge clock) begin
        if (!reset) begin
            status <= 2'b00;
        end else begin
            status[0] <= timer_ev | (status[0] & ~stat_clr);
            status[1] <= btn_rise | (status[1] & ~stat_clr);
        end
    end

    assign timer_flag = status[0];

    always_comb begin
        dmemrdata = 16'h0000;
        if (reset) begin
            if (!is_io) begin
                dmemrdata = ram[ram_idx];
            end else begin
                case (io_off)
                    OFF_LED:    dmemrdata = {8'h00, led};
                    OFF_INPUT:  dmemrdata = {11'b0, db_val};
                    OFF_CYCLE:  dmemrdata = cycle;
                    OFF_TCMP:   dmemrdata = tcmp;
                    OFF_STATUS: dmemrdata = {14'b0, status};
                    default:    dmemrdata = 16'h0000;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a short debounce window (DB_CYCLES=4).
module tb_dmem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] dmemaddr = 16'h0000;
    logic [15:0] dmemwdata = 16'h0000;
    logic        dmemwrite = 1'b0;
    logic        dmemread = 1'b0;
    logic [15:0] dmemrdata;
    logic [3:0]  sw = 4'b0000;
    logic        btn = 1'b0;
    logic [7:0]  led;
    logic        timer_flag;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp_cyc = 16'h0000;

    dmem_responder #(.ADDR_W(10), .DB_CYCLES(4), .DB_W(4)) dut (
        .clock(clock), .reset(reset), .dmemaddr(dmemaddr), .dmemwdata(dmemwdata),
        .dmemwrite(dmemwrite), .dmemread(dmemread), .dmemrdata(dmemrdata),
        .sw(sw), .btn(btn), .led(led), .timer_flag(timer_flag)
    );

    always #5 clock = ~clock;

    // Reference cycle count: edges since reset was last released.
    always @(posedge clock) begin
        if (!reset) exp_cyc <= 16'h0000;
        else        exp_cyc <= exp_cyc + 16'h0001;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        dmemaddr  = a;
        dmemwdata = d;
        dmemwrite = 1'b1;
        step(1);
        dmemwrite = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(3);
        dmemaddr = 16'h0010; #1;
        n_vec++; if (dmemrdata !== 16'h0000) begin n_err++; $display("FAIL rdata_in_reset got %h want 0000", dmemrdata); end
        reset = 1'b1;
        dmemaddr = 16'hFF04; #1;
        n_vec++; if (dmemrdata !== 16'h0000) begin n_err++; $display("FAIL cycle_after_release got %h want 0000", dmemrdata); end
        n_vec++; if (led !== 8'h00) begin n_err++; $display("FAIL led_reset got %h want 00", led); end
        n_vec++; if (timer_flag !== 1'b0) begin n_err++; $display("FAIL flag_reset got %b want 0", timer_flag); end
        dmemaddr = 16'hFF06; #1;
        n_vec++; if (dmemrdata !== 16'h0000) begin n_err++; $display("FAIL tcmp_reset got %h want 0000", dmemrdata); end
        dmemaddr = 16'hFF08; #1;
        n_vec++; if (dmemrdata !== 16'h0000) begin n_err++; $display("FAIL status_reset got %h want 0000", dmemrdata); end
        dmemaddr = 16'hFF02; #1;
        n_vec++; if (dmemrdata !== 16'h0000) begin n_err++; $display("FAIL input_reset got %h want 0000", dmemrdata); end
    endtask

    task automatic test_ram();
        do_write(16'h0010, 16'h1234);
        do_write(16'h0012, 16'hBEEF);
        dmemaddr = 16'h0010; #1;
        n_vec++; if (dmemrdata !== 16'h1234) begin n_err++; $display("FAIL ram_0010 got %h want 1234", dmemrdata); end
        dmemaddr = 16'h0011; #1;
        n_vec++; if (dmemrdata !== 16'h1234) begin n_err++; $display("FAIL ram_0011 got %h want 1234", dmemrdata); end
        dmemaddr = 16'h0012; #1;
        n_vec++; if (dmemrdata !== 16'hBEEF) begin n_err++; $display("FAIL ram_0012 got %h want beef", dmemrdata); end
        dmemaddr = 16'h0810; #1;
        n_vec++; if (dmemrdata !== 16'h1234) begin n_err++; $display("FAIL ram_alias got %h want 1234", dmemrdata); end
        dmemaddr = 16'h0010; dmemwdata = 16'h5555; dmemwrite = 1'b1; dmemread = 1'b1; #1;
        n_vec++; if (dmemrdata !== 16'h1234) begin n_err++; $display("FAIL ram_rw_old got %h want 1234", dmemrdata); end
        step(1);
        dmemwrite = 1'b0; dmemread = 1'b0; #1;
        n_vec++; if (dmemrdata !== 16'h5555) begin n_err++; $display("FAIL ram_rw_new got %h want 5555", dmemrdata); end
    endtask

    task automatic test_io();
        do_write(16'hFF00, 16'h00A5);
        n_vec++; if (led !== 8'hA5) begin n_err++; $display("FAIL led_write got %h want a5", led); end
        dmemaddr = 16'hFF00; #1;
        n_vec++; if (dmemrdata !== 16'h00A5) begin n_err++; $display("FAIL led_read got %h want 00a5", dmemrdata); end
        do_write(16'hFF04, 16'hFFFF);
        dmemaddr = 16'hFF04; #1;
        n_vec++; if (dmemrdata !== exp_cyc) begin n_err++; $display("FAIL cycle_ro_a got %h want %h", dmemrdata, exp_cyc); end
        step(1);
        n_vec++; if (dmemrdata !== exp_cyc) begin n_err++; $display("FAIL cycle_ro_b got %h want %h", dmemrdata, exp_cyc); end
        do_write(16'hFF0C, 16'h7777);
        dmemaddr = 16'hFF0C; #1;
        n_vec++; if (dmemrdata !== 16'h0000) begin n_err++; $display("FAIL unmapped_read got %h want 0000", dmemrdata); end
        do_write(16'hFF02, 16'h001F);
        dmemaddr = 16'hFF02; #1;
        n_vec++; if (dmemrdata !== 16'h0000) begin n_err++; $display("FAIL input_ro got %h want 0000", dmemrdata); end
    endtask

    task automatic test_debounce();
        dmemaddr = 16'hFF02;
        sw = 4'b1010;
        step(5);
        n_vec++; if (dmemrdata !== 16'h0000) begin n_err++; $display("FAIL db_early got %h want 0000", dmemrdata); end
        step(1);
        n_vec++; if (dmemrdata !== 16'h000A) begin n_err++; $display("FAIL db_settle got %h want 000a", dmemrdata); end
        sw = 4'b1011;
        step(3);
        sw = 4'b1010;
        n_vec++; if (dmemrdata !== 16'h000A) begin n_err++; $display("FAIL db_glitch_mid got %h want 000a", dmemrdata); end
        step(8);
        n_vec++; if (dmemrdata !== 16'h000A) begin n_err++; $display("FAIL db_glitch_after got %h want 000a", dmemrdata); end
    endtask

    task automatic test_timer();
        do_write(16'hFF06, 16'h0005);
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) step(1);
            n_vec++; if (timer_flag !== 1'b0) begin n_err++; $display("FAIL timer_early%0d got %b want 0", i, timer_flag); end
        end
        step(4 - 3);
        step(1);
        n_vec++; if (timer_flag !== 1'b1) begin n_err++; $display("FAIL timer_first got %b want 1", timer_flag); end
        dmemaddr = 16'hFF08; dmemread = 1'b1; #1;
        n_vec++; if (dmemrdata !== 16'h0001) begin n_err++; $display("FAIL status_timer got %h want 0001", dmemrdata); end
        step(1);
        dmemread = 1'b0;
        n_vec++; if (timer_flag !== 1'b0) begin n_err++; $display("FAIL timer_cleared got %b want 0", timer_flag); end
        step(3);
        dmemread = 1'b1; #1;
        n_vec++; if (dmemrdata !== 16'h0000) begin n_err++; $display("FAIL status_preclear got %h want 0000", dmemrdata); end
        step(1);
        dmemread = 1'b0;
        n_vec++; if (timer_flag !== 1'b1) begin n_err++; $display("FAIL timer_set_wins got %b want 1", timer_flag); end
        dmemaddr = 16'hFF06; #1;
        n_vec++; if (dmemrdata !== 16'h0005) begin n_err++; $display("FAIL tcmp_read got %h want 0005", dmemrdata); end
        dmemaddr = 16'hFF08; dmemread = 1'b1;
        step(1);
        dmemread = 1'b0;
        do_write(16'hFF06, 16'h0000);
        n_vec++; if (timer_flag !== 1'b0) begin n_err++; $display("FAIL timer_off got %b want 0", timer_flag); end
    endtask

    task automatic test_button();
        btn = 1'b1;
        dmemaddr = 16'hFF08;
        step(5);
        n_vec++; if (dmemrdata !== 16'h0000) begin n_err++; $display("FAIL btn_early got %h want 0000", dmemrdata); end
        step(1);
        dmemaddr = 16'hFF02; #1;
        n_vec++; if (dmemrdata !== 16'h001A) begin n_err++; $display("FAIL btn_input got %h want 001a", dmemrdata); end
        dmemaddr = 16'hFF08; dmemread = 1'b1; #1;
        n_vec++; if (dmemrdata !== 16'h0002) begin n_err++; $display("FAIL btn_status got %h want 0002", dmemrdata); end
        step(1);
        n_vec++; if (dmemrdata !== 16'h0000) begin n_err++; $display("FAIL btn_reread got %h want 0000", dmemrdata); end
        step(1);
        dmemread = 1'b0;
        btn = 1'b0;
        step(8);
        n_vec++; if (dmemrdata !== 16'h0000) begin n_err++; $display("FAIL btn_release got %h want 0000", dmemrdata); end
        dmemaddr = 16'hFF02; #1;
        n_vec++; if (dmemrdata !== 16'h000A) begin n_err++; $display("FAIL btn_release_input got %h want 000a", dmemrdata); end
    endtask

    task automatic test_reset_mid();
        do_write(16'hFF00, 16'h000F);
        do_write(16'hFF06, 16'h0007);
        step(3);
        reset = 1'b0;
        dmemaddr = 16'h0012; dmemwdata = 16'h9999; dmemwrite = 1'b1; #1;
        n_vec++; if (dmemrdata !== 16'h0000) begin n_err++; $display("FAIL mid_rdata_forced got %h want 0000", dmemrdata); end
        step(1);
        reset = 1'b1; dmemwrite = 1'b0;
        n_vec++; if (led !== 8'h00) begin n_err++; $display("FAIL mid_led got %h want 00", led); end
        dmemaddr = 16'hFF00; #1;
        n_vec++; if (dmemrdata !== 16'h0000) begin n_err++; $display("FAIL mid_led_read got %h want 0000", dmemrdata); end
        dmemaddr = 16'hFF06; #1;
        n_vec++; if (dmemrdata !== 16'h0000) begin n_err++; $display("FAIL mid_tcmp got %h want 0000", dmemrdata); end
        dmemaddr = 16'hFF08; #1;
        n_vec++; if (dmemrdata !== 16'h0000) begin n_err++; $display("FAIL mid_status got %h want 0000", dmemrdata); end
        dmemaddr = 16'hFF02; #1;
        n_vec++; if (dmemrdata !== 16'h0000) begin n_err++; $display("FAIL mid_input got %h want 0000", dmemrdata); end
        dmemaddr = 16'hFF04; #1;
        n_vec++; if (dmemrdata !== 16'h0000) begin n_err++; $display("FAIL mid_cycle0 got %h want 0000", dmemrdata); end
        step(1);
        n_vec++; if (dmemrdata !== 16'h0001) begin n_err++; $display("FAIL mid_cycle1 got %h want 0001", dmemrdata); end
        dmemaddr = 16'h0010; #1;
        n_vec++; if (dmemrdata !== 16'h5555) begin n_err++; $display("FAIL mid_ram_keep got %h want 5555", dmemrdata); end
        dmemaddr = 16'h0012; #1;
        n_vec++; if (dmemrdata !== 16'hBEEF) begin n_err++; $display("FAIL mid_ram_blocked got %h want beef", dmemrdata); end
        step(8);
        n_vec++; if (timer_flag !== 1'b0) begin n_err++; $display("FAIL mid_timer_gone got %b want 0", timer_flag); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_io();
        test_debounce();
        test_timer();
        test_button();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
